idu_issue_queue: RTL and testbench

Parametrised successor to the single-entry decode stage. Sits between IFU and EXU and holds up to DEPTH fetched instructions in a circular queue, so fetch no longer stalls on every EXU back-pressure cycle. Presents the head instruction to EXU with register operands resolved through NFWD generic forwarding channels. Applies load-use stalls per channel, flushes on redirect, and keeps issue/stall performance counters.

---
 rtl/idu_issue_queue.sv | 160 ++++++++++++++++
 tb/tb_idu_issue_queue.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_issue_queue.sv
// Decode issue queue: buffers up to DEPTH fetched instructions between IFU and EXU and
// presents the head with operands resolved through NFWD forwarding channels.
module idu_issue_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  parameter int NFWD  = 3,
  parameter int CNT_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [XLEN-1:0]          in_pc,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_inst,
  output logic [XLEN-1:0]          out_pc,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  input  logic [XLEN-1:0]          rf_rs1_data,
  input  logic [XLEN-1:0]          rf_rs2_data,
  input  logic [NFWD-1:0]          fwd_valid,
  input  logic [5*NFWD-1:0]        fwd_rd,
  input  logic [XLEN*NFWD-1:0]     fwd_data,
  input  logic [NFWD-1:0]          fwd_pending,
  output logic [XLEN-1:0]          out_rs1_data,
  output logic [XLEN-1:0]          out_rs2_data,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [CNT_W-1:0]         issue_count,
  output logic [CNT_W-1:0]         stall_count,
  output logic [1:0]               dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   ONE_CNT   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] ONE_PTR   = PTR_W'(1);
  localparam logic [CNT_W-1:0] ONE_PERF  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_READY = 2'd1,
    S_STALL = 2'd2
  } state_t;

  logic [31:0]      inst_mem_q [DEPTH];
  logic [XLEN-1:0]  pc_mem_q   [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [CNT_W-1:0] issue_q, issue_d, stall_q, stall_d;
  state_t           state_q, state_d;

  logic       empty, full, push, pop, hazard;
  logic       use_rs1, use_rs2, rs1_pend, rs2_pend;
  logic [6:0] opcode;

  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_CNT);
  assign out_inst  = inst_mem_q[head_q];
  assign out_pc    = pc_mem_q[head_q];
  assign out_rs1   = out_inst[19:15];
  assign out_rs2   = out_inst[24:20];
  assign opcode    = out_inst[6:0];

  assign use_rs1 = !(opcode == 7'b0110111 || opcode == 7'b0010111 || opcode == 7'b1101111);
  assign use_rs2 =  (opcode == 7'b0110011 || opcode == 7'b1100011 || opcode == 7'b0100011);

  // Scan oldest to youngest so the lowest-index (youngest) match is the last one written.
  always_comb begin
    out_rs1_data = rf_rs1_data;
    out_rs2_data = rf_rs2_data;
    rs1_pend     = 1'b0;
    rs2_pend     = 1'b0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && use_rs1 && out_rs1 != 5'd0 && fwd_rd[5*i +: 5] == out_rs1) begin
        out_rs1_data = fwd_data[XLEN*i +: XLEN];
        rs1_pend     = fwd_pending[i];
      end
      if (fwd_valid[i] && use_rs2 && out_rs2 != 5'd0 && fwd_rd[5*i +: 5] == out_rs2) begin
        out_rs2_data = fwd_data[XLEN*i +: XLEN];
        rs2_pend     = fwd_pending[i];
      end
    end
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready depends only on registered occupancy; out_valid never looks at out_ready.
  assign hazard    = !empty && (rs1_pend || rs2_pend);
  assign in_ready  = !full;
  assign out_valid = !empty && !hazard && !flush;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  assign occupancy   = count_q;
  assign issue_count = issue_q;
  assign stall_count = stall_q;
  assign dbg_state   = state_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    issue_d = issue_q;
    stall_d = stall_q;
    state_d = state_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      state_d = S_EMPTY;
    end else begin
      if (push) tail_d = tail_q + ONE_PTR;
      if (pop) begin
        head_d  = head_q + ONE_PTR;
        issue_d = issue_q + ONE_PERF;
      end
      if (push && !pop)      count_d = count_q + ONE_CNT;
      else if (pop && !push) count_d = count_q - ONE_CNT;
      if (hazard) stall_d = stall_q + ONE_PERF;
      case (state_q)
        S_EMPTY: if (push) state_d = S_READY;
        S_READY: begin
          if (count_d == '0) state_d = S_EMPTY;
          else if (hazard)   state_d = S_STALL;
        end
        S_STALL: if (!hazard) state_d = S_READY;
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      issue_q <= '0;
      stall_q <= '0;
      state_q <= S_EMPTY;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      issue_q <= issue_d;
      stall_q <= stall_d;
      state_q <= state_d;
    end
  end

  // Entry payloads carry no reset; they are only read while occupancy is non-zero.
  always_ff @(posedge clock) begin
    if (push) begin
      inst_mem_q[tail_q] <= in_inst;
      pc_mem_q[tail_q]   <= in_pc;
    end
  end

endmodule

// File: tb/tb_idu_issue_queue.sv
// Bench for idu_issue_queue: directed scenarios plus a random phase, all outputs
// compared every cycle against a queue-based reference model.
module tb_idu_issue_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int NFWD  = 3;
  localparam int CNT_W = 32;
  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int EW    = 32 + XLEN;

  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  logic                   clock, reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]            in_inst, out_inst;
  logic [XLEN-1:0]        in_pc, out_pc, rf_rs1_data, rf_rs2_data, out_rs1_data, out_rs2_data;
  logic [4:0]             out_rs1, out_rs2;
  logic [NFWD-1:0]        fwd_valid, fwd_pending;
  logic [5*NFWD-1:0]      fwd_rd;
  logic [XLEN*NFWD-1:0]   fwd_data;
  logic [OCC_W-1:0]       occupancy;
  logic [CNT_W-1:0]       issue_count, stall_count;
  logic [1:0]             dbg_state;

  idu_issue_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .NFWD(NFWD), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .fwd_pending(fwd_pending),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .occupancy(occupancy), .issue_count(issue_count), .stall_count(stall_count),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0]    exp_q[$];
  logic [CNT_W-1:0] exp_issue;
  logic [CNT_W-1:0] exp_stall;
  int               n_checks;
  int               n_err;
  bit               mon_en;
  logic [6:0]       ops [8] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                                7'b1101111, 7'b1100011, 7'b0100011, 7'b0000011};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, op};
  endfunction

  function automatic bit reads_rs1(input logic [6:0] op);
    return !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return (op == 7'b0110011 || op == 7'b1100011 || op == 7'b0100011);
  endfunction

  // Returns {pending, value}: first matching channel from youngest, else the regfile value.
  function automatic logic [XLEN:0] resolve(input logic [4:0] rs, input bit used,
                                            input logic [XLEN-1:0] rf);
    for (int i = 0; i < NFWD; i++)
      if (used && rs != 5'd0 && fwd_valid[i] && fwd_rd[5*i +: 5] == rs)
        return {fwd_pending[i], fwd_data[XLEN*i +: XLEN]};
    return {1'b0, rf};
  endfunction

  // ---------------- monitor + reference model ----------------
  always @(negedge clock) begin : monitor
    logic [31:0]     h_inst;
    logic [XLEN-1:0] h_pc;
    logic [XLEN:0]   r1, r2;
    bit              ne, hz, mv, room;
    ne     = exp_q.size() != 0;
    room   = exp_q.size() < DEPTH;
    h_inst = ne ? exp_q[0][EW-1:XLEN] : 32'd0;
    h_pc   = ne ? exp_q[0][XLEN-1:0]  : '0;
    r1     = resolve(h_inst[19:15], reads_rs1(h_inst[6:0]), rf_rs1_data);
    r2     = resolve(h_inst[24:20], reads_rs2(h_inst[6:0]), rf_rs2_data);
    hz     = ne && (r1[XLEN] || r2[XLEN]);
    mv     = ne && !hz && !flush;
    if (mon_en) begin
      chk("out_valid", 64'(out_valid), 64'(mv));
      chk("in_ready", 64'(in_ready), 64'(room));
      chk("occupancy", 64'(occupancy), 64'(exp_q.size()));
      chk("issue_count", 64'(issue_count), 64'(exp_issue));
      chk("stall_count", 64'(stall_count), 64'(exp_stall));
      if (ne) begin
        chk("out_inst", 64'(out_inst), 64'(h_inst));
        chk("out_pc", 64'(out_pc), 64'(h_pc));
        chk("out_rs1", 64'(out_rs1), 64'(h_inst[19:15]));
        chk("out_rs2", 64'(out_rs2), 64'(h_inst[24:20]));
      end
      if (mv) begin
        chk("out_rs1_data", 64'(out_rs1_data), 64'(r1[XLEN-1:0]));
        chk("out_rs2_data", 64'(out_rs2_data), 64'(r2[XLEN-1:0]));
      end
    end
    if (reset) begin
      exp_q.delete();
      exp_issue = '0;
      exp_stall = '0;
    end else if (flush) begin
      exp_q.delete();
    end else begin
      if (mv && out_ready) begin
        void'(exp_q.pop_front());
        exp_issue++;
      end
      if (hz) exp_stall++;
      if (in_valid && room) exp_q.push_back({in_inst, in_pc});
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fwd_off();
    fwd_valid   = '0;
    fwd_pending = '0;
    fwd_rd      = '0;
    fwd_data    = '0;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    mon_en   = 1'b0;
    reset    = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_inst  = '0;
    in_pc    = '0;
    out_ready = 1'b0;
    rf_rs1_data = 32'hAAAA;
    rf_rs2_data = 32'hBBBB;
    fwd_off();
    tick();
    mon_en = 1'b1;
    @(negedge clock);
    chk("reset_occupancy", 64'(occupancy), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    tick();
    reset = 1'b0;

    // Fill: five offers with EXU stalled, then drain in order
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_inst = mk(OP_IMM, 5'd1, 5'd0, 5'd0);
      in_pc   = 32'h8000_0000 + 32'(4 * k);
      if (k == 4) begin
        @(negedge clock);
        chk("fill_in_ready", 64'(in_ready), 64'd0);
        chk("fill_occupancy", 64'(occupancy), 64'd4);
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      chk("drain_pc", 64'(out_pc), 64'(32'h8000_0000 + 32'(4 * j)));
      tick();
    end
    @(negedge clock);
    chk("drain_empty", 64'(occupancy), 64'd0);

    // Streaming: 16 back-to-back addi
    in_valid = 1'b1;
    for (int s = 0; s < 16; s++) begin
      in_inst = mk(OP_IMM, 5'(s), 5'd0, 5'd0);
      in_pc   = 32'h1000 + 32'(4 * s);
      if (s > 0) begin
        @(negedge clock);
        chk("stream_occupancy", 64'(occupancy), 64'd1);
        chk("stream_valid", 64'(out_valid), 64'd1);
      end
      tick();
    end
    in_valid = 1'b0;
    tick();
    @(negedge clock);
    chk("stream_issue_count", 64'(issue_count), 64'd20);
    chk("stream_stall_count", 64'(stall_count), 64'd0);

    // Forwarding priority: add x3,x1,x2
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = mk(OP_REG, 5'd3, 5'd1, 5'd2);
    in_pc     = 32'h2000;
    tick();
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    fwd_valid   = 3'b111;
    fwd_rd      = {5'd1, 5'd2, 5'd1};
    fwd_data    = {32'h22, 32'h33, 32'h11};
    @(negedge clock);
    chk("fwd_rs1_data", 64'(out_rs1_data), 64'h11);
    chk("fwd_rs2_data", 64'(out_rs2_data), 64'h33);
    chk("fwd_valid_out", 64'(out_valid), 64'd1);
    tick();
    fwd_off();

    // Load-use: add x5,x4,x0 against a pending load to x4
    in_valid = 1'b1;
    in_inst  = mk(OP_REG, 5'd5, 5'd4, 5'd0);
    in_pc    = 32'h3000;
    tick();
    in_valid    = 1'b0;
    fwd_valid   = 3'b001;
    fwd_rd      = {5'd0, 5'd0, 5'd4};
    fwd_pending = 3'b001;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("loaduse_stalled", 64'(out_valid), 64'd0);
      tick();
    end
    fwd_pending = 3'b000;
    fwd_data    = {64'd0, 32'hDEAD};
    @(negedge clock);
    chk("loaduse_stall_count", 64'(stall_count), 64'd3);
    chk("loaduse_rs1_data", 64'(out_rs1_data), 64'hDEAD);
    chk("loaduse_release", 64'(out_valid), 64'd1);
    tick();
    fwd_pending = 3'b001;
    in_valid    = 1'b1;
    in_inst     = mk(OP_LUI, 5'd6, 5'd4, 5'd0);
    in_pc       = 32'h3004;
    tick();
    in_valid = 1'b0;
    @(negedge clock);
    chk("lui_no_stall", 64'(out_valid), 64'd1);
    tick();
    fwd_rd   = {5'd0, 5'd0, 5'd0};
    in_valid = 1'b1;
    in_inst  = mk(OP_REG, 5'd7, 5'd0, 5'd0);
    in_pc    = 32'h3008;
    tick();
    in_valid = 1'b0;
    @(negedge clock);
    chk("x0_no_stall", 64'(out_valid), 64'd1);
    tick();
    fwd_off();
    @(negedge clock);
    chk("loaduse_issue_count", 64'(issue_count), 64'd24);
    chk("loaduse_stall_final", 64'(stall_count), 64'd3);

    // Flush with a simultaneous push
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_inst = mk(OP_IMM, 5'd2, 5'd0, 5'd0);
      in_pc   = 32'h4000 + 32'(4 * k);
      tick();
    end
    flush     = 1'b1;
    out_ready = 1'b1;
    in_pc     = 32'h4F00;
    @(negedge clock);
    chk("flush_pre_occupancy", 64'(occupancy), 64'd3);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    chk("flush_occupancy", 64'(occupancy), 64'd0);
    tick();
    in_valid = 1'b1;
    in_pc    = 32'h5000;
    tick();
    in_valid = 1'b0;
    @(negedge clock);
    chk("post_flush_pc", 64'(out_pc), 64'h5000);
    chk("post_flush_valid", 64'(out_valid), 64'd1);
    tick();

    // Pointer wrap: 2*DEPTH+1 push/pop pairs
    in_valid = 1'b1;
    for (int k = 0; k < 2 * DEPTH + 1; k++) begin
      in_inst = mk(OP_IMM, 5'(k), 5'd0, 5'd0);
      in_pc   = 32'h6000 + 32'(4 * k);
      tick();
    end
    in_valid = 1'b0;
    tick();

    // Random traffic with forwarding, hazards and flushes
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 19) == 0;
      in_inst   = mk(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 31)),
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      in_pc     = $urandom;
      rf_rs1_data = $urandom;
      rf_rs2_data = $urandom;
      fwd_valid = 3'($urandom);
      for (int i = 0; i < NFWD; i++) begin
        fwd_rd[5*i +: 5]        = 5'($urandom_range(0, 3));
        fwd_data[XLEN*i +: XLEN] = $urandom;
        fwd_pending[i]          = $urandom_range(0, 3) == 0;
      end
      tick();
    end
    fwd_off();
    flush     = 1'b1;
    in_valid  = 1'b0;
    tick();
    flush = 1'b0;

    // Reset (with flush) in the middle of a non-empty stream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_inst = mk(OP_IMM, 5'd9, 5'd0, 5'd0);
      in_pc   = 32'h7000 + 32'(4 * k);
      tick();
    end
    reset = 1'b1;
    flush = 1'b1;
    tick();
    reset    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clock);
    chk("rst_mid_occupancy", 64'(occupancy), 64'd0);
    chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_in_ready", 64'(in_ready), 64'd1);
    chk("rst_mid_issue", 64'(issue_count), 64'd0);
    chk("rst_mid_stall", 64'(stall_count), 64'd0);
    tick();
    in_valid = 1'b1;
    in_pc    = 32'h7100;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    chk("rst_resume_pc", 64'(out_pc), 64'h7100);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
